// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - byte-stream input and instruction-memory write port of the boot loader
// master is the loader side; slave is the byte source / memory side.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );
endinterface

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - framed byte-stream loader for the CPU instruction memory
// Holds the CPU in reset until a frame (sync, count, payload, checksum) loads with a matching sum.
module imem_boot_loader #(
  parameter int          DEPTH     = 16,
  parameter int          ADDR_W    = 4,
  parameter int          DATA_W    = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                clk,
  input  logic                reset_n,
  imem_boot_loader_if.master  bus,
  output logic                cpu_hold,
  output logic                load_done,
  output logic                load_err
);

  // One extra bit so a full DEPTH-word count is representable without wrapping.
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_word_cnt;
  logic [CNT_W-1:0]   r_count_n;
  logic [7:0]         r_hi;
  logic [7:0]         r_sum;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [DATA_W-1:0]  r_wr_data;
  logic               r_cpu_hold;
  logic               r_load_done;
  logic               r_load_err;

  logic               w_ready;
  logic               w_accept;
  logic               w_is_sync;
  logic               w_bad_count;
  logic [CNT_W-1:0]   w_cnt_next;

  assign w_ready     = reset_n && (r_state != S_WRITE);
  assign w_accept    = bus.in_valid && w_ready;
  assign w_is_sync   = (bus.in_data == SYNC_BYTE);
  assign w_bad_count = (bus.in_data == 8'd0) || ({24'd0, bus.in_data} > 32'(DEPTH));
  assign w_cnt_next  = r_word_cnt + CNT_W'(1);

  assign bus.in_ready = w_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign cpu_hold     = r_cpu_hold;
  assign load_done    = r_load_done;
  assign load_err     = r_load_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_word_cnt  <= '0;
      r_count_n   <= '0;
      r_hi        <= '0;
      r_sum       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_cpu_hold  <= 1'b1;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        // DONE and ERR restart exactly like IDLE on a sync byte.
        S_IDLE, S_DONE, S_ERR: begin
          if (w_accept && w_is_sync) begin
            r_state     <= S_COUNT;
            r_cpu_hold  <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
            r_word_cnt  <= '0;
            r_sum       <= '0;
          end
        end
        S_COUNT: begin
          if (w_accept) begin
            if (w_bad_count) begin
              r_state    <= S_ERR;
              r_cpu_hold <= 1'b1;
              r_load_err <= 1'b1;
            end else begin
              r_count_n <= bus.in_data[CNT_W-1:0];
              r_state   <= S_HI;
            end
          end
        end
        S_HI: begin
          if (w_accept) begin
            r_hi    <= bus.in_data;
            r_sum   <= r_sum + bus.in_data;
            r_state <= S_LO;
          end
        end
        S_LO: begin
          if (w_accept) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_word_cnt[ADDR_W-1:0];
            r_wr_data <= DATA_W'({r_hi, bus.in_data});
            r_sum     <= r_sum + bus.in_data;
            r_state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_word_cnt <= w_cnt_next;
          r_state    <= (w_cnt_next == r_count_n) ? S_CSUM : S_HI;
        end
        S_CSUM: begin
          if (w_accept) begin
            if (bus.in_data == r_sum) begin
              r_state     <= S_DONE;
              r_cpu_hold  <= 1'b0;
              r_load_done <= 1'b1;
            end else begin
              r_state    <= S_ERR;
              r_cpu_hold <= 1'b1;
              r_load_err <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
